// File: rtl/decode_queue_stage.sv
// RV32I decode stage feeding a DEPTH-entry queue of decoded instructions between fetch and execute.
// Define DECODE_QUEUE_MEXT_EN to decode RV32M (OP opcode, funct7 0000001) instead of flagging it.
module decode_queue_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [4:0]       out_rs1_id_o,
  output logic [4:0]       out_rs2_id_o,
  output logic [4:0]       out_rd_id_o,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [2:0]       out_mem_width_o,
  output logic [3:0]       out_alu_op_o,
  output logic             out_alu_src1_o,
  output logic [1:0]       out_alu_src2_o,
  output logic             out_mem_to_reg_o,
  output logic             out_mem_write_o,
  output logic             out_reg_write_o,
  output logic             out_branch_o,
  output logic             out_invert_branch_o,
  output logic             out_jump_o,
  output logic [1:0]       out_type_instr_o,
  output logic             out_exception_o,
  output logic             out_md_valid_o,
  output logic [2:0]       out_md_op_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0100;
  localparam logic [3:0] AluOr   = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluShl  = 4'b1000;
  localparam logic [3:0] AluShr  = 4'b1010;
  localparam logic [3:0] AluSha  = 4'b1011;
  localparam logic [3:0] AluSlt  = 4'b1100;
  localparam logic [3:0] AluSltu = 4'b1101;
  localparam logic [3:0] AluB    = 4'b1111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      mem_width;
    logic [3:0]      alu_op;
    logic            alu_src1;
    logic [1:0]      alu_src2;
    logic            mem_to_reg;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            invert_branch;
    logic            jump;
    logic [1:0]      type_instr;
    logic            exception;
`ifdef DECODE_QUEUE_MEXT_EN
    logic            md_valid;
    logic [2:0]      md_op;
`endif
  } entry_t;

  // alt selects SUB over ADD and arithmetic over logical right shift
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluShl;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSha : AluShr;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + 1'b1;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  entry_t          dec;
  logic            illegal;

  assign opcode = in_instr_i[6:0];
  assign funct3 = in_instr_i[14:12];
  assign funct7 = in_instr_i[31:25];
  assign imm_i  = {{(XLEN-11){in_instr_i[31]}}, in_instr_i[30:20]};
  assign imm_s  = {{(XLEN-11){in_instr_i[31]}}, in_instr_i[30:25], in_instr_i[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr_i[31]}}, in_instr_i[7], in_instr_i[30:25],
                   in_instr_i[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){in_instr_i[31]}}, in_instr_i[30:12], 12'b0};
  assign imm_j  = {{(XLEN-20){in_instr_i[31]}}, in_instr_i[19:12], in_instr_i[20],
                   in_instr_i[30:21], 1'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, in_instr_i[24:20]};

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (opcode)
      OpLui: begin
        dec.rd        = in_instr_i[11:7];
        dec.imm       = imm_u;
        dec.alu_op    = AluB;
        dec.alu_src2  = 2'b01;
        dec.reg_write = 1'b1;
      end
      OpAuipc: begin
        dec.rd        = in_instr_i[11:7];
        dec.imm       = imm_u;
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = 2'b01;
        dec.reg_write = 1'b1;
      end
      OpJal: begin
        dec.rd         = in_instr_i[11:7];
        dec.imm        = imm_j;
        dec.alu_src1   = 1'b1;
        dec.alu_src2   = 2'b11;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.type_instr = 2'b01;
      end
      OpJalr: begin
        dec.rd         = in_instr_i[11:7];
        dec.rs1        = in_instr_i[19:15];
        dec.imm        = imm_i;
        dec.alu_src1   = 1'b1;
        dec.alu_src2   = 2'b11;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.type_instr = 2'b11;
        illegal        = (funct3 != 3'b000);
      end
      OpBranch: begin
        dec.rs1        = in_instr_i[19:15];
        dec.rs2        = in_instr_i[24:20];
        dec.imm        = imm_b;
        dec.branch     = 1'b1;
        dec.type_instr = 2'b01;
        case (funct3)
          3'b000:  begin dec.alu_op = AluSub;  dec.invert_branch = 1'b1; end
          3'b001:  dec.alu_op = AluSub;
          3'b100:  dec.alu_op = AluSlt;
          3'b101:  begin dec.alu_op = AluSlt;  dec.invert_branch = 1'b1; end
          3'b110:  dec.alu_op = AluSltu;
          3'b111:  begin dec.alu_op = AluSltu; dec.invert_branch = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        dec.rd         = in_instr_i[11:7];
        dec.rs1        = in_instr_i[19:15];
        dec.imm        = imm_i;
        dec.mem_width  = funct3;
        dec.alu_src2   = 2'b01;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        illegal        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OpStore: begin
        dec.rs1       = in_instr_i[19:15];
        dec.rs2       = in_instr_i[24:20];
        dec.imm       = imm_s;
        dec.mem_width = funct3;
        dec.alu_src2  = 2'b01;
        dec.mem_write = 1'b1;
        illegal       = (funct3 >= 3'b011);
      end
      OpImm: begin
        dec.rd        = in_instr_i[11:7];
        dec.rs1       = in_instr_i[19:15];
        dec.imm       = imm_i;
        dec.alu_src2  = 2'b01;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        // Shift immediates carry only a zero-extended shamt
        if (funct3 == 3'b001) begin
          dec.imm = imm_sh;
          illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_sh;
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OpReg: begin
        dec.rd        = in_instr_i[11:7];
        dec.rs1       = in_instr_i[19:15];
        dec.rs2       = in_instr_i[24:20];
        dec.reg_write = 1'b1;
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          dec.alu_op = alu_from_f3(funct3, funct7[5]);
`ifdef DECODE_QUEUE_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          dec.md_valid = 1'b1;
          dec.md_op    = funct3;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec           = '0;
      dec.exception = 1'b1;
    end
    dec.pc = in_pc_i;
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic             push, pop;

  assign in_ready_o  = (count_q < CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  // An all-zero word is a fetch bubble: handshake completes but nothing is stored
  assign push = in_valid_i && in_ready_o && !flush_i && (in_instr_i != 32'h0);
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign out_pc_o            = head.pc;
  assign out_rs1_id_o        = head.rs1;
  assign out_rs2_id_o        = head.rs2;
  assign out_rd_id_o         = head.rd;
  assign out_imm_o           = head.imm;
  assign out_mem_width_o     = head.mem_width;
  assign out_alu_op_o        = head.alu_op;
  assign out_alu_src1_o      = head.alu_src1;
  assign out_alu_src2_o      = head.alu_src2;
  assign out_mem_to_reg_o    = head.mem_to_reg;
  assign out_mem_write_o     = head.mem_write;
  assign out_reg_write_o     = head.reg_write;
  assign out_branch_o        = head.branch;
  assign out_invert_branch_o = head.invert_branch;
  assign out_jump_o          = head.jump;
  assign out_type_instr_o    = head.type_instr;
  assign out_exception_o     = head.exception;
`ifdef DECODE_QUEUE_MEXT_EN
  assign out_md_valid_o      = head.md_valid;
  assign out_md_op_o         = head.md_op;
`else
  assign out_md_valid_o      = 1'b0;
  assign out_md_op_o         = 3'b000;
`endif
  assign count_o             = count_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage: driver queues hand-decoded expectations,
// a negedge monitor pops and compares whenever the head entry is consumed.
module tb_decode_queue_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [2:0]       out_mw, out_mdo;
  logic [3:0]       out_alu;
  logic             out_s1, out_m2r, out_mwr, out_rw, out_br, out_inv, out_jmp, out_exc, out_mdv;
  logic [1:0]       out_s2, out_ty;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  mw;
    logic [3:0]  alu;
    logic        s1;
    logic [1:0]  s2;
    logic        m2r, mwr, rw, br, inv, jmp;
    logic [1:0]  ty;
    logic        exc, mdv;
    logic [2:0]  mdo;
  } exp_t;

  exp_t act;
  assign act = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_mw, out_alu, out_s1, out_s2,
                out_m2r, out_mwr, out_rw, out_br, out_inv, out_jmp, out_ty, out_exc, out_mdv,
                out_mdo};

  decode_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_rs1_id_o(out_rs1), .out_rs2_id_o(out_rs2), .out_rd_id_o(out_rd),
    .out_imm_o(out_imm), .out_mem_width_o(out_mw), .out_alu_op_o(out_alu),
    .out_alu_src1_o(out_s1), .out_alu_src2_o(out_s2), .out_mem_to_reg_o(out_m2r),
    .out_mem_write_o(out_mwr), .out_reg_write_o(out_rw), .out_branch_o(out_br),
    .out_invert_branch_o(out_inv), .out_jump_o(out_jmp), .out_type_instr_o(out_ty),
    .out_exception_o(out_exc), .out_md_valid_o(out_mdv), .out_md_op_o(out_mdo),
    .count_o(count)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, a, e);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_entry: got %0h, expected no entry", act);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("entry_pc_%0h", mon_e.pc), act, mon_e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction, waiting (bounded) for in_ready; queue the expectation on acceptance
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                       input bit enq);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout: in_ready stayed %0b, required 1", in_ready);
    end else if (enq) begin
      e.pc = pc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 32'h0;
  endtask

  exp_t e_add, e_addi, e_lui, e_none;
  exp_t vec_e [10];
  logic [31:0] vec_i [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = '0;
    out_ready = 1'b0;

    e_none = '0;
    e_add = '0;  e_add.rs1 = 5'd1; e_add.rs2 = 5'd2; e_add.rd = 5'd3; e_add.rw = 1'b1;
    e_addi = '0; e_addi.rd = 5'd1; e_addi.imm = 32'd5; e_addi.s2 = 2'b01; e_addi.rw = 1'b1;
    e_lui = '0;  e_lui.rd = 5'd5; e_lui.imm = 32'h12345000; e_lui.alu = 4'b1111;
    e_lui.s2 = 2'b01; e_lui.rw = 1'b1;

    for (int i = 0; i < 10; i++) vec_e[i] = '0;
    vec_i[0] = 32'h0020A063; vec_e[0].exc = 1'b1;
    vec_i[1] = 32'h00208063; vec_e[1].rs1 = 5'd1; vec_e[1].rs2 = 5'd2; vec_e[1].alu = 4'b0001;
    vec_e[1].br = 1'b1; vec_e[1].inv = 1'b1; vec_e[1].ty = 2'b01;
    vec_i[2] = 32'h4030D093; vec_e[2].rd = 5'd1; vec_e[2].rs1 = 5'd1; vec_e[2].imm = 32'd3;
    vec_e[2].alu = 4'b1011; vec_e[2].s2 = 2'b01; vec_e[2].rw = 1'b1;
    vec_i[3] = 32'h008000EF; vec_e[3].rd = 5'd1; vec_e[3].imm = 32'd8; vec_e[3].s1 = 1'b1;
    vec_e[3].s2 = 2'b11; vec_e[3].jmp = 1'b1; vec_e[3].rw = 1'b1; vec_e[3].ty = 2'b01;
    vec_i[4] = 32'hFE20AE23; vec_e[4].rs1 = 5'd1; vec_e[4].rs2 = 5'd2;
    vec_e[4].imm = 32'hFFFFFFFC; vec_e[4].mw = 3'b010; vec_e[4].s2 = 2'b01; vec_e[4].mwr = 1'b1;
    vec_i[5] = 32'h00812283; vec_e[5].rd = 5'd5; vec_e[5].rs1 = 5'd2; vec_e[5].imm = 32'd8;
    vec_e[5].mw = 3'b010; vec_e[5].s2 = 2'b01; vec_e[5].m2r = 1'b1; vec_e[5].rw = 1'b1;
    vec_i[6] = 32'h00008067; vec_e[6].rs1 = 5'd1; vec_e[6].s1 = 1'b1; vec_e[6].s2 = 2'b11;
    vec_e[6].jmp = 1'b1; vec_e[6].rw = 1'b1; vec_e[6].ty = 2'b11;
    vec_i[7] = 32'h402081B3; vec_e[7] = e_add; vec_e[7].alu = 4'b0001;
    vec_i[8] = 32'h002081B0; vec_e[8].exc = 1'b1;
    vec_i[9] = 32'h022081B3;
`ifdef DECODE_QUEUE_MEXT_EN
    vec_e[9].rs1 = 5'd1; vec_e[9].rs2 = 5'd2; vec_e[9].rd = 5'd3; vec_e[9].rw = 1'b1;
    vec_e[9].mdv = 1'b1; vec_e[9].mdo = 3'b000;
`else
    vec_e[9].exc = 1'b1;
`endif

    // Reset state
    #3;
    check("reset_count", count, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_fields", act, e_none);
    #9 rst_n = 1'b1;
    step(1);

    // Single add, one-cycle latency
    out_ready = 1'b1;
    offer(32'h002081B3, 32'h100, e_add, 1'b1);
    check("latency_out_valid", out_valid, 1);
    step(2);

    // Fill, stall a third offer, then drain in order
    out_ready = 1'b0;
    offer(32'h00500093, 32'h104, e_addi, 1'b1);
    offer(32'h123452B7, 32'h108, e_lui, 1'b1);
    check("full_count", count, 2);
    check("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1 check("full_in_ready_with_out_ready", in_ready, 0);
    offer(32'h002081B3, 32'h10C, e_add, 1'b1);
    step(4);
    check("drained_count", count, 0);

    // Directed decode vectors, back to back
    for (int i = 0; i < 10; i++) offer(vec_i[i], 32'h1000 + 32'(i * 4), vec_e[i], 1'b1);
    step(4);
    check("vectors_drained", count, 0);

    // Flush while full with an offer pending
    out_ready = 1'b0;
    offer(32'h00500093, 32'h200, e_addi, 1'b1);
    offer(32'h123452B7, 32'h204, e_lui, 1'b1);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h208; flush = 1'b1;
    step(1);
    flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
    sb.delete();
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    // Flush with room in the queue: same-cycle push must be dropped
    offer(32'h00500093, 32'h20C, e_addi, 1'b1);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h210; flush = 1'b1;
    step(1);
    flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
    sb.delete();
    check("flush_push_dropped", count, 0);
    out_ready = 1'b1;
    step(3);
    check("flush_not_delivered", out_valid, 0);
    offer(32'h002081B3, 32'h214, e_add, 1'b1);
    step(3);

    // Bubble: handshake completes but nothing is queued
    in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h300;
    @(negedge clk);
    check("bubble_in_ready", in_ready, 1);
    step(1);
    in_valid = 1'b0;
    check("bubble_count", count, 0);
    check("bubble_out_valid", out_valid, 0);

    // Asynchronous reset with entries queued
    out_ready = 1'b0;
    offer(32'h00500093, 32'h400, e_addi, 1'b1);
    offer(32'h123452B7, 32'h404, e_lui, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_count", count, 0);
    check("async_reset_in_ready", in_ready, 1);
    check("async_reset_fields", act, e_none);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step(3);
    check("post_reset_out_valid", out_valid, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
Registered RV32I instruction-decode stage with a parametrised decoded-instruction queue between fetch and execute. Accepts {instr, pc} over a valid/ready handshake and decodes it with full illegal-encoding checks. Buffers up to DEPTH decoded entries so fetch decouples from execute stalls. Supports pipeline flush and optional RV32M decode.

Parameters:
XLEN, 32, width of pc and imm outputs (imm sign-extended to XLEN)
DEPTH, 2, decoded-entry queue depth; power of two, >=1
CNT_W, $clog2(DEPTH+1), width of occupancy output

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
flush  in  1  discard all queued entries and any same-cycle input
in_valid  in  1  fetch offers instruction
in_ready  out  1  queue can accept; = (count < DEPTH), registered-path only, no dependence on out_ready
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  execute consumes head
out_pc  out  XLEN  pc of head entry
out_rs1_id / out_rs2_id / out_rd_id  out  5 each  register indices
out_imm  out  XLEN  decoded immediate (I/S/B/U/J; shamt zero-extended for SLLI/SRLI/SRAI)
out_mem_width  out  3  funct3
out_alu_op  out  4  ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110, SHL 1000, SHR 1010, SHA 1011, SLT 1100, SLTU 1101, B 1111
out_alu_src1  out  1  0 rs1, 1 pc
out_alu_src2  out  2  00 rs2, 01 imm, 11 const 4
out_mem_to_reg / out_mem_write / out_reg_write / out_branch / out_invert_branch / out_jump  out  1 each
out_type_instr  out  2  next-pc: 00 pc+4, 01 pc+imm, 11 rs1+imm
out_exception  out  1  illegal instruction; all other control flags forced 0
out_md_valid  out  1  entry is M-extension op
out_md_op  out  3  M-extension funct3
count  out  CNT_W  queue occupancy

Behaviour:
- Reset (async assert, sync release): queue empty, count=0, out_valid=0, in_ready=1 (DEPTH>=1), all out_* fields 0.
- Push when in_valid&&in_ready&&!flush; pop when out_valid&&out_ready&&!flush. Simultaneous push+pop: count unchanged, order preserved.
- Latency: instruction accepted at edge N appears at head after edge N (out_valid high in cycle N+1) when queue was empty; no combinational in->out path.
- Decode is performed before enqueue; queue stores decoded fields, not raw instr.
- instr==32'h0 (bubble): accepted (handshake completes) but not enqueued; count unchanged.
- Full (count==DEPTH): in_ready=0 even if out_ready=1 that cycle.
- Pointers wrap modulo DEPTH.
- flush: next edge count=0, out_valid=0; same-cycle push/pop ignored. Flush has priority over everything except reset.
- Illegal (exception=1, reg_write=mem_write=branch=jump=0, alu_op=ADD): unknown opcode; R-type funct7 not 0000000, or 0100000 with funct3 other than 000/101; I-type SLLI funct7!=0, SRLI/SRAI funct7 not 0000000/0100000; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>=011; JALR funct3!=000; instr[1:0]!=11.
- Branches: BEQ SUB inv=1, BNE SUB inv=0, BLT SLT inv=0, BGE SLT inv=1, BLTU SLTU inv=0, BGEU SLTU inv=1; alu_src2=00, type_instr=01.
- JAL: src1=1, src2=11, jump=1, reg_write=1, type 01. JALR same but type 11. AUIPC: src1=1, src2=01, ADD. LUI: src2=01, alu_op=B. LOAD: mem_to_reg=1, ADD, imm. STORE: mem_write=1, ADD, imm.
- Exception entries are still enqueued and handshake normally.

Optional Feature:
DECODE_QUEUE_MEXT_EN: defined -> opcode 0110011 with funct7 0000001 decodes as M op: out_md_valid=1, out_md_op=funct3, reg_write=1, alu_op=ADD, src2=00. Undefined -> same encoding flagged illegal; out_md_valid and out_md_op tied 0.

Test Plan:
- Reset then push 0x002081B3 (add x3,x1,x2), pc=0x100 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_op=0000, reg_write=1, pc=0x100.
- Push 0x00500093 then 0x123452B7 with out_ready=0 -> count=2, in_ready=0; third offer stalls; then out_ready=1 -> addi imm=5 then lui imm=0x12345000 alu_op=1111, in order.
- Push 0x0020A063 (branch funct3 010) -> exception=1, branch=0; push 0x00208063 -> branch=1, alu_op=0001, invert=1, imm=0.
- Queue full, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed input not delivered.
- Push 0x022081B3 -> with DECODE_QUEUE_MEXT_EN md_valid=1, md_op=000, exception=0; without, exception=1.
- Push 32'h0 -> handshake completes, count stays 0, out_valid=0; assert rst_n=0 mid-queue -> outputs zero immediately.
